uart_stream_tx: RTL and testbench
=================================

Name: uart_stream_tx

Overview:
Parametrised, FIFO-buffered UART transmitter. It replaces the fixed single-byte tx path that drives the board serial line (tx_data) from the top level. A valid/ready stream of result words is queued, then serialised with configurable data width, parity and stop bits. An enable gate holds transmission off until the host side is ready.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200, truncated); must be >= 2
DATA_BITS, 8, payload bits per frame, 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 16, queue entries; power of 2, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enb  in  1  transmit enable; gates frame start only
s_data  in  DATA_BITS  word to send
s_valid  in  1  s_data valid
s_ready  out  1  FIFO not full
clr_ovf  in  1  clears overflow flag
tx_data  out  1  serial line, idle high
busy  out  1  frame in progress
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued
overflow  out  1  sticky: s_valid seen while s_ready low

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst. All outputs registered except s_ready, which is combinational: !full.
- Reset values: tx_data=1, busy=0, fifo_count=0, overflow=0, s_ready=1. FSM goes to IDLE and the FIFO is emptied.
- Reset mid-frame: tx_data returns to 1 on the first rst edge. The partial frame is abandoned and queued words are discarded.
- Push: s_valid & s_ready at an edge writes s_data and increments fifo_count.
  - No push when full, even if a pop happens the same cycle.
  - Simultaneous push and pop with the FIFO not full leaves fifo_count unchanged.
- Overflow: s_valid & !s_ready sets overflow; it holds until clr_ovf=1 or rst. If set and clear occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: at an edge where enb=1 and FIFO not empty.
  - The head word is popped into a shift register in that cycle.
  - tx_data=0 and busy=1 from that edge.
  - Latency: a word pushed into an empty FIFO in IDLE with enb=1 drives tx low 1 cycle after the push edge.
- Bit timing: each bit is held exactly CLKS_PER_BIT cycles by a down-counter.
- START -> DATA: data is sent LSB first, DATA_BITS bits.
- DATA -> PARITY: only if PARITY_MODE != 0.
  - Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - With PARITY_MODE=0, DATA goes directly to STOP.
- STOP: tx_data=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) cycles.
- End of last stop bit:
  - If enb=1 and the FIFO is not empty: pop and enter START on the same edge, with no idle gap; busy stays 1.
  - Otherwise: go to IDLE with busy=0.
- enb deassert mid-frame: the current frame completes; no new frame starts. Pushes are still accepted while enb=0.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
- CLKS_PER_BIT=4, PARITY_MODE=1, push 0xA5 with enb=1 -> tx low 1 cycle after push. Each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,0(parity),1. busy high for 44 cycles, then 0.
- Same config, PARITY_MODE=2, STOP_BITS=2, push 0x07 -> parity bit 0, two stop bits. Frame is 48 cycles.
- enb=0, push 3 words -> tx stays 1 and fifo_count=3. Raise enb -> 3 frames back-to-back with no idle cycle between stop and start; fifo_count steps 2,1,0.
- FIFO_DEPTH=4, enb=0, push 5 words -> s_ready=0 after the 4th push, overflow=1 after the 5th. clr_ovf pulse -> overflow=0. The FIFO keeps words 1-4.
- Assert rst during DATA of frame 1 with 2 words queued -> next cycle tx_data=1, busy=0, fifo_count=0. After release, no frame starts without a new push.
- Drop enb during DATA -> the frame finishes with correct bits; the next queued word is not sent until enb=1.

Source files
------------

// File: rtl/uart_stream_tx.sv
// FIFO-buffered UART transmitter: a valid/ready word stream is queued and then
// serialised LSB first, with optional parity and one or two stop bits.
module uart_stream_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enb,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          clr_ovf,
    output logic                          tx_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic          ODD_PAR    = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic [AW:0]          count_d;
    logic                 ovf_q;

    state_t               state_q;
    logic                 tx_q;
    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign head    = mem_q[rd_ptr_q];

    // A pop is the start of a frame: from IDLE, or chained straight off the
    // final stop-bit cycle so consecutive frames have no idle gap.
    always_comb begin
        pop = 1'b0;
        if (enb && !empty) begin
            if (state_q == S_IDLE) begin
                pop = 1'b1;
            end else if (state_q == S_STOP && cnt_q == '0 && stop_q == LAST_STOP) begin
                pop = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (s_valid && full) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_RELOAD;
                        shift_q <= head;
                        par_q   <= (^head) ^ ODD_PAR;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                        cnt_q   <= CNT_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= CNT_RELOAD;
                        if (bit_q == LAST_BIT) begin
                            if (PARITY_MODE != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                                stop_q  <= 1'b0;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        cnt_q   <= CNT_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        if (stop_q == LAST_STOP) begin
                            if (pop) begin
                                state_q <= S_START;
                                tx_q    <= 1'b0;
                                busy_q  <= 1'b1;
                                cnt_q   <= CNT_RELOAD;
                                shift_q <= head;
                                par_q   <= (^head) ^ ODD_PAR;
                            end else begin
                                state_q <= S_IDLE;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            stop_q <= stop_q + 1'b1;
                            cnt_q  <= CNT_RELOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data    = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_stream_tx.sv
// Bench for uart_stream_tx: two differently configured instances, a driver
// that queues expected words, and per-instance monitors that check every line cycle.
module tb_uart_stream_tx;
    localparam int CPB_A = 4, DB_A = 8, PM_A = 1, SB_A = 1, DEP_A = 4;
    localparam int CPB_B = 3, DB_B = 7, PM_B = 2, SB_B = 2, DEP_B = 8;
    localparam int CPB_V[2] = '{CPB_A, CPB_B};
    localparam int DB_V[2]  = '{DB_A, DB_B};
    localparam int PM_V[2]  = '{PM_A, PM_B};
    localparam int SB_V[2]  = '{SB_A, SB_B};
    localparam int DEP_V[2] = '{DEP_A, DEP_B};

    logic clk = 1'b0;
    logic rst, enb, clr_ovf;
    logic [DB_A-1:0] sd_a;
    logic sv_a, sr_a, tx_a, busy_a, ovf_a;
    logic [$clog2(DEP_A):0] cnt_a;
    logic [DB_B-1:0] sd_b;
    logic sv_b, sr_b, tx_b, busy_b, ovf_b;
    logic [$clog2(DEP_B):0] cnt_b;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int mcnt[2];
    bit mon_busy[2];
    logic [8:0] exp_qa[$];
    logic [8:0] exp_qb[$];
    int start_a[$];
    int start_b[$];

    uart_stream_tx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A), .PARITY_MODE(PM_A),
                     .STOP_BITS(SB_A), .FIFO_DEPTH(DEP_A)) dut_a (
        .clk(clk), .rst(rst), .enb(enb), .s_data(sd_a), .s_valid(sv_a),
        .s_ready(sr_a), .clr_ovf(clr_ovf), .tx_data(tx_a), .busy(busy_a),
        .fifo_count(cnt_a), .overflow(ovf_a));

    uart_stream_tx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B), .PARITY_MODE(PM_B),
                     .STOP_BITS(SB_B), .FIFO_DEPTH(DEP_B)) dut_b (
        .clk(clk), .rst(rst), .enb(enb), .s_data(sd_b), .s_valid(sv_b),
        .s_ready(sr_b), .clr_ovf(clr_ovf), .tx_data(tx_b), .busy(busy_b),
        .fifo_count(cnt_b), .overflow(ovf_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic get_tx(input int i);
        return (i == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_busy(input int i);
        return (i == 0) ? busy_a : busy_b;
    endfunction

    function automatic int frame_len(input int i);
        return CPB_V[i] * (1 + DB_V[i] + ((PM_V[i] != 0) ? 1 : 0) + SB_V[i]);
    endfunction

    // Line level expected at bit slot pos of a frame carrying word w.
    function automatic logic exp_level(input int i, input logic [8:0] w, input int pos);
        logic p;
        p = 1'b0;
        if (pos == 0) return 1'b0;
        if (pos <= DB_V[i]) return w[pos-1];
        if (PM_V[i] != 0 && pos == DB_V[i] + 1) begin
            for (int k = 0; k < DB_V[i]; k++) p = p ^ w[k];
            return (PM_V[i] == 2) ? ~p : p;
        end
        return 1'b1;
    endfunction

    task automatic monitor(input int i);
        logic [8:0] w;
        bit pending;
        bit ab;
        int nbits;
        string tag;
        pending = 0;
        nbits = 1 + DB_V[i] + ((PM_V[i] != 0) ? 1 : 0) + SB_V[i];
        tag = (i == 0) ? "a" : "b";
        forever begin
            if (!pending) @(negedge clk);
            pending = 0;
            if (rst || get_tx(i) !== 1'b0) continue;
            mon_busy[i] = 1;
            w = '0;
            if (i == 0) begin
                if (exp_qa.size() == 0) check({"unexpected_frame_", tag}, 1, 0);
                else w = exp_qa.pop_front();
                start_a.push_back(cyc);
            end else begin
                if (exp_qb.size() == 0) check({"unexpected_frame_", tag}, 1, 0);
                else w = exp_qb.pop_front();
                start_b.push_back(cyc);
            end
            if (mcnt[i] > 0) mcnt[i]--;
            ab = 0;
            for (int pos = 0; pos < nbits && !ab; pos++) begin
                for (int k = 0; k < CPB_V[i] && !ab; k++) begin
                    if (pos != 0 || k != 0) @(negedge clk);
                    if (rst) begin
                        ab = 1;
                    end else begin
                        check($sformatf("tx_%s_w%0h_pos%0d", tag, w, pos), get_tx(i), exp_level(i, w, pos));
                        check($sformatf("busy_%s_pos%0d", tag, pos), get_busy(i), 1);
                    end
                end
            end
            mon_busy[i] = 0;
            if (!ab) begin
                @(negedge clk);
                if (!rst) begin
                    if (get_tx(i) === 1'b0) pending = 1;
                    else check({"busy_after_frame_", tag}, get_busy(i), 0);
                end
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input logic [8:0] w);
        logic [8:0] wm;
        wm = w & 9'((1 << DB_V[i]) - 1);
        if (i == 0) begin
            check("s_ready_a", sr_a, 1);
            sd_a = wm[DB_A-1:0];
            sv_a = 1'b1;
        end else begin
            check("s_ready_b", sr_b, 1);
            sd_b = wm[DB_B-1:0];
            sv_b = 1'b1;
        end
        tick();
        sv_a = 1'b0;
        sv_b = 1'b0;
        if (i == 0) exp_qa.push_back(wm);
        else exp_qb.push_back(wm);
        mcnt[i]++;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_qa.size() != 0 || exp_qb.size() != 0 || mon_busy[0] || mon_busy[1]) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", (n < budget), 1);
        tick(2);
    endtask

    task automatic wait_starts_a(input int want, input int budget);
        int n;
        n = 0;
        while (start_a.size() < want && n < budget) begin
            tick();
            n++;
        end
        check("start_timeout", (n < budget), 1);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; clr_ovf = 1'b0;
        sv_a = 1'b0; sv_b = 1'b0; sd_a = '0; sd_b = '0;
        mcnt[0] = 0; mcnt[1] = 0;
        mon_busy[0] = 0; mon_busy[1] = 0;
        fork
            monitor(0);
            monitor(1);
        join_none
        tick(3);
        rst = 1'b0;
        tick();

        check("rst_tx_a", tx_a, 1);      check("rst_busy_a", busy_a, 0);
        check("rst_cnt_a", cnt_a, 0);    check("rst_ovf_a", ovf_a, 0);
        check("rst_ready_a", sr_a, 1);
        check("rst_tx_b", tx_b, 1);      check("rst_busy_b", busy_b, 0);
        check("rst_cnt_b", cnt_b, 0);    check("rst_ovf_b", ovf_b, 0);

        // Single frame, even parity: start bit lands one cycle after the push edge.
        enb = 1'b1;
        push(0, 9'h0A5);
        check("lat_tx_still_high", tx_a, 1);
        tick();
        check("lat_tx_low", tx_a, 0);
        check("lat_busy", busy_a, 1);
        wait_idle(200);

        // Odd parity, two stop bits on the second instance.
        push(1, 9'h007);
        wait_idle(200);

        // Queue while disabled, then release: frames must chain with no gap.
        enb = 1'b0;
        start_a.delete();
        for (int k = 0; k < 3; k++) push(0, 9'($urandom_range(0, 255)));
        tick(5);
        check("hold_tx", tx_a, 1);
        check("hold_cnt", cnt_a, 3);
        check("hold_busy", busy_a, 0);
        enb = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_starts_a(f + 1, 200);
            check($sformatf("b2b_cnt_%0d", f), cnt_a, 2 - f);
        end
        wait_idle(300);
        check("b2b_gap_0", start_a[1] - start_a[0], frame_len(0));
        check("b2b_gap_1", start_a[2] - start_a[1], frame_len(0));

        // Fill, overflow, clear, and set-beats-clear.
        enb = 1'b0;
        for (int k = 0; k < DEP_A; k++) push(0, 9'($urandom_range(0, 255)));
        check("full_ready", sr_a, 0);
        check("full_ovf", ovf_a, 0);
        check("full_cnt", cnt_a, DEP_A);
        sd_a = 8'h3C; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        check("ovf_set", ovf_a, 1);
        check("ovf_cnt", cnt_a, DEP_A);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("ovf_clr", ovf_a, 0);
        sv_a = 1'b1; clr_ovf = 1'b1; tick(); sv_a = 1'b0; clr_ovf = 1'b0;
        check("ovf_set_wins", ovf_a, 1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("ovf_clr2", ovf_a, 0);
        enb = 1'b1;
        wait_idle(400);

        // Reset in the middle of a data bit with two words still queued.
        enb = 1'b0;
        start_a.delete();
        for (int k = 0; k < 3; k++) push(0, 9'($urandom_range(0, 255)));
        enb = 1'b1;
        wait_starts_a(1, 200);
        tick(CPB_A * 3);
        rst = 1'b1;
        exp_qa.delete(); exp_qb.delete();
        mcnt[0] = 0; mcnt[1] = 0;
        tick();
        check("midrst_tx", tx_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_cnt", cnt_a, 0);
        rst = 1'b0;
        tick(60);
        check("postrst_no_frame", start_a.size(), 1);
        check("postrst_tx", tx_a, 1);
        check("postrst_busy", busy_a, 0);

        // Drop enable mid-frame: frame completes, next word waits.
        start_a.delete();
        enb = 1'b0;
        push(0, 9'($urandom_range(0, 255)));
        push(0, 9'($urandom_range(0, 255)));
        enb = 1'b1;
        wait_starts_a(1, 200);
        tick(CPB_A * 3);
        enb = 1'b0;
        tick(frame_len(0) + 10);
        check("enb_off_starts", start_a.size(), 1);
        check("enb_off_cnt", cnt_a, 1);
        check("enb_off_tx", tx_a, 1);
        check("enb_off_busy", busy_a, 0);
        enb = 1'b1;
        wait_idle(200);
        check("enb_on_starts", start_a.size(), 2);

        // Random traffic on both instances with enable jitter.
        for (int it = 0; it < 1500; it++) begin
            int i;
            enb = ($urandom_range(0, 9) != 0);
            i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 && mcnt[i] < DEP_V[i]) push(i, 9'($urandom_range(0, 511)));
            else tick();
        end
        enb = 1'b1;
        wait_idle(4000);
        check("final_cnt_a", cnt_a, 0);
        check("final_cnt_b", cnt_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
